// File: rtl/uart_hand_packet_scheduler.sv
// Frames top/bottom hand coordinate snapshots into sync + payload + checksum packets
// and feeds them one byte at a time into the UART transmitter's start/busy handshake.
module uart_hand_packet_scheduler #(
    parameter int SYNC_BYTES  = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        enable_in,
    input  logic        continuous_in,
    input  logic        update_in,
    input  logic [11:0] x_top_in,
    input  logic [11:0] y_top_in,
    input  logic [11:0] x_bottom_in,
    input  logic [11:0] y_bottom_in,
    input  logic        tx_busy_in,
    output logic        tx_start_out,
    output logic [7:0]  tx_data_out,
    output logic        packet_active_out,
    output logic        packet_done_out,
    output logic [7:0]  overrun_count_out
);

    localparam logic [3:0] SYNC_IDX = 4'(SYNC_BYTES);
    localparam logic [3:0] LAST_IDX = 4'(SYNC_BYTES + 6);
    localparam logic [7:0] TIMEOUT  = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  timer;

    logic [11:0] sh_xt, sh_yt, sh_xb, sh_yb;
    logic        pending;
    logic [11:0] pk_xt, pk_yt, pk_xb, pk_yb;

    logic [7:0]  payload [6];
    logic [7:0]  sum;
    logic [7:0]  checksum;
    logic        start_ok;

    function automatic logic [7:0] clamp(input logic [7:0] b);
        return (b == 8'hFF) ? 8'hFE : b;
    endfunction

    always_comb begin
        payload[0] = clamp(pk_xt[11:4]);
        payload[1] = clamp(pk_yt[7:0]);
        payload[2] = clamp({pk_xt[3:0], pk_yt[11:8]});
        payload[3] = clamp(pk_xb[11:4]);
        payload[4] = clamp(pk_yb[7:0]);
        payload[5] = clamp({pk_xb[3:0], pk_yb[11:8]});
        sum        = payload[0] + payload[1] + payload[2] + payload[3] + payload[4] + payload[5];
        checksum   = clamp(sum);
    end

    function automatic logic [7:0] byte_at(input logic [3:0] i);
        logic [3:0] off;
        off = i - SYNC_IDX;
        if (i < SYNC_IDX) return 8'hFF;
        case (off)
            4'd0:    return payload[0];
            4'd1:    return payload[1];
            4'd2:    return payload[2];
            4'd3:    return payload[3];
            4'd4:    return payload[4];
            4'd5:    return payload[5];
            default: return checksum;
        endcase
    endfunction

    // update_in counts as a trigger so a strobe seen in IDLE reaches LOAD on the very next cycle.
    assign start_ok = enable_in && (pending || update_in || continuous_in);

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            sh_xt             <= '0;
            sh_yt             <= '0;
            sh_xb             <= '0;
            sh_yb             <= '0;
            pending           <= 1'b0;
            overrun_count_out <= 8'd0;
        end else if (update_in) begin
            sh_xt   <= x_top_in;
            sh_yt   <= y_top_in;
            sh_xb   <= x_bottom_in;
            sh_yb   <= y_bottom_in;
            pending <= 1'b1;
            // In LOAD the pending snapshot is being consumed, so rewriting it loses nothing.
            if (pending && state != LOAD && overrun_count_out != 8'hFF)
                overrun_count_out <= overrun_count_out + 8'd1;
        end else if (state == LOAD) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            state             <= IDLE;
            idx               <= 4'd0;
            timer             <= 8'd0;
            pk_xt             <= '0;
            pk_yt             <= '0;
            pk_xb             <= '0;
            pk_yb             <= '0;
            tx_start_out      <= 1'b0;
            tx_data_out       <= 8'd0;
            packet_active_out <= 1'b0;
            packet_done_out   <= 1'b0;
        end else begin
            tx_start_out    <= 1'b0;
            packet_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state             <= LOAD;
                        packet_active_out <= 1'b1;
                    end
                end
                LOAD: begin
                    pk_xt <= sh_xt;
                    pk_yt <= sh_yt;
                    pk_xb <= sh_xb;
                    pk_yb <= sh_yb;
                    idx   <= 4'd0;
                    // Byte 0 is always a sync byte, so it does not need the packet registers yet.
                    if (!tx_busy_in) begin
                        tx_start_out <= 1'b1;
                        tx_data_out  <= 8'hFF;
                        timer        <= 8'd0;
                        state        <= WAIT_ACK;
                    end else begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy_in) begin
                        tx_start_out <= 1'b1;
                        tx_data_out  <= byte_at(idx);
                        timer        <= 8'd0;
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy_in) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMEOUT) begin
                        tx_start_out <= 1'b1;
                        timer        <= 8'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_in) begin
                        if (idx == LAST_IDX) begin
                            state           <= DONE;
                            packet_done_out <= 1'b1;
                        end else begin
                            idx          <= idx + 4'd1;
                            tx_start_out <= 1'b1;
                            tx_data_out  <= byte_at(idx + 4'd1);
                            timer        <= 8'd0;
                            state        <= WAIT_ACK;
                        end
                    end
                end
                DONE: begin
                    if (start_ok) begin
                        state <= LOAD;
                    end else begin
                        state             <= IDLE;
                        packet_active_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hand_packet_scheduler.sv
// Bench for uart_hand_packet_scheduler: a transmitter model plus an expected-byte queue
// built from the packet framing rules, advanced one negedge at a time by a single process.
module tb_uart_hand_packet_scheduler;

    localparam int SB = 3;
    localparam int AT = 16;
    localparam int NB = SB + 7;

    logic        clk = 1'b0;
    logic        rst_n, enable, continuous, update, tx_busy;
    logic [11:0] xt, yt, xb, yb;
    logic        tx_start, active, done;
    logic [7:0]  tx_data, overrun;

    always #5 clk = ~clk;

    uart_hand_packet_scheduler #(.SYNC_BYTES(SB), .ACK_TIMEOUT(AT)) dut (
        .clk_in            (clk),
        .rst_in_n          (rst_n),
        .enable_in         (enable),
        .continuous_in     (continuous),
        .update_in         (update),
        .x_top_in          (xt),
        .y_top_in          (yt),
        .x_bottom_in       (xb),
        .y_bottom_in       (yb),
        .tx_busy_in        (tx_busy),
        .tx_start_out      (tx_start),
        .tx_data_out       (tx_data),
        .packet_active_out (active),
        .packet_done_out   (done),
        .overrun_count_out (overrun)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0, rx_count = 0, pulses = 0, done_count = 0;
    int         busy_cnt = 0, busy_len = 10, ign_cyc = 0;
    bit         ignore_next = 0, ign_seen = 0;
    logic [7:0] last_data = 8'd0;

    logic [7:0] lit1 [10] = '{8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h56, 8'h34, 8'h78, 8'hBC, 8'h9A, 8'h6A};
    logic [7:0] lit2 [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input logic [11:0] a, b, c, d, input int i);
        logic [7:0] p [6];
        int s;
        p[0] = a[11:4];
        p[1] = b[7:0];
        p[2] = {a[3:0], b[11:8]};
        p[3] = c[11:4];
        p[4] = d[7:0];
        p[5] = {c[3:0], d[11:8]};
        s = 0;
        for (int k = 0; k < 6; k++) begin
            if (p[k] == 8'hFF) p[k] = 8'hFE;
            s = s + int'(p[k]);
        end
        s = s % 256;
        if (s == 255) s = 254;
        if (i < SB) return 8'hFF;
        if (i < SB + 6) return p[i - SB];
        return 8'(s);
    endfunction

    task automatic push_pkt(input logic [11:0] a, b, c, d);
        for (int i = 0; i < NB; i++) exp_q.push_back(pkt_byte(a, b, c, d, i));
    endtask

    // Advance to the next negedge, then act as transmitter and scoreboard for that cycle.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst_n && !tx_start) check("data_hold", tx_data, last_data);
        last_data = tx_data;
        if (tx_start) begin
            pulses++;
            check("start_while_busy", busy_cnt, 0);
            check("active_on_pulse", active, 1);
            if (ignore_next) begin
                ignore_next = 0;
                ign_seen    = 1;
                ign_cyc     = cyc;
            end else begin
                if (ign_seen) begin
                    check("repulse_gap", cyc - ign_cyc, AT + 1);
                    ign_seen = 0;
                end
                rx_count++;
                if (exp_q.size() > 0) check("byte", tx_data, exp_q.pop_front());
                else check("byte_expected", exp_q.size(), 1);
                busy_cnt = busy_len;
                tx_busy  = 1'b1;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (done) done_count++;
    endtask

    task automatic do_update(input logic [11:0] a, b, c, d);
        xt = a; yt = b; xb = c; yb = d;
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    task automatic wait_done_to(input int target, input int max, input string name);
        int k = 0;
        while (done_count < target && k < max) begin
            step();
            k++;
        end
        check(name, done_count >= target, 1);
    endtask

    task automatic wait_rx_to(input int target, input int max, input string name);
        int k = 0;
        while (rx_count < target && k < max) begin
            step();
            k++;
        end
        check(name, rx_count >= target, 1);
    endtask

    function automatic logic [11:0] rnd12();
        case ($urandom_range(0, 3))
            0:       return 12'hFFF;
            1:       return 12'hFF0 | 12'($urandom_range(0, 15));
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        logic [11:0] ra, rb, rc, rd;
        int rx0, d0, p0, upd_cyc;
        rst_n = 1'b0; enable = 1'b1; continuous = 1'b0; update = 1'b0; tx_busy = 1'b0;
        xt = '0; yt = '0; xb = '0; yb = '0;
        repeat (3) step();
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NB; i++) begin
            check("model_pin1", pkt_byte(12'h123, 12'h456, 12'h789, 12'hABC, i), lit1[i]);
            check("model_pin2", pkt_byte(12'hFF0, 12'h0FF, 12'h000, 12'h000, i), lit2[i]);
        end

        // Basic packet with first-pulse latency
        rx0 = rx_count; d0 = done_count;
        push_pkt(12'h123, 12'h456, 12'h789, 12'hABC);
        upd_cyc = cyc;
        do_update(12'h123, 12'h456, 12'h789, 12'hABC);
        check("load_active", active, 1);
        step();
        check("first_pulse_lat", tx_start, 1);
        check("first_pulse_cyc", cyc - upd_cyc, 2);
        wait_done_to(d0 + 1, 400, "t1_done");
        repeat (3) step();
        check("t1_idle_active", active, 0);
        check("t1_bytes", rx_count - rx0, NB);
        check("t1_done_count", done_count - d0, 1);
        check("t1_queue", exp_q.size(), 0);

        // Clamp packet
        d0 = done_count;
        push_pkt(12'hFF0, 12'h0FF, 12'h000, 12'h000);
        do_update(12'hFF0, 12'h0FF, 12'h000, 12'h000);
        wait_done_to(d0 + 1, 400, "t2_done");
        check("t2_queue", exp_q.size(), 0);

        // Ignored first start pulse
        rx0 = rx_count; d0 = done_count;
        ignore_next = 1;
        push_pkt(12'h321, 12'h654, 12'h987, 12'hCBA);
        do_update(12'h321, 12'h654, 12'h987, 12'hCBA);
        wait_done_to(d0 + 1, 500, "t3_done");
        check("t3_bytes", rx_count - rx0, NB);
        check("t3_repulse_seen", ign_seen, 0);
        check("t3_queue", exp_q.size(), 0);

        // Randomized packets with random transmitter busy time
        for (int n = 0; n < 8; n++) begin
            busy_len = $urandom_range(1, 12);
            ra = rnd12(); rb = rnd12(); rc = rnd12(); rd = rnd12();
            d0 = done_count;
            push_pkt(ra, rb, rc, rd);
            do_update(ra, rb, rc, rd);
            wait_done_to(d0 + 1, 600, "rnd_done");
            repeat ($urandom_range(2, 5)) step();
            check("rnd_queue", exp_q.size(), 0);
        end
        busy_len = 10;
        check("overrun_none", overrun, 0);

        // Three updates during an active packet
        d0 = done_count;
        push_pkt(12'h111, 12'h222, 12'h333, 12'h444);
        do_update(12'h111, 12'h222, 12'h333, 12'h444);
        wait_rx_to(rx_count + 1, 50, "ov_first_byte");
        do_update(12'hA01, 12'hA02, 12'hA03, 12'hA04);
        step();
        do_update(12'hB01, 12'hB02, 12'hB03, 12'hB04);
        step();
        push_pkt(12'hC01, 12'hC02, 12'hC03, 12'hC04);
        do_update(12'hC01, 12'hC02, 12'hC03, 12'hC04);
        wait_done_to(d0 + 2, 800, "ov_done");
        p0 = pulses;
        repeat (40) step();
        check("ov_count", overrun, 2);
        check("ov_no_extra", pulses - p0, 0);
        check("ov_queue", exp_q.size(), 0);

        // Saturation while disabled
        enable = 1'b0;
        p0 = pulses;
        for (int n = 0; n < 300; n++) do_update(rnd12(), rnd12(), rnd12(), rnd12());
        check("sat_count", overrun, 8'hFF);
        check("sat_no_pulse", pulses - p0, 0);
        d0 = done_count;
        push_pkt(xt, yt, xb, yb);
        enable = 1'b1;
        wait_done_to(d0 + 1, 400, "sat_done");
        check("sat_queue", exp_q.size(), 0);

        // Continuous resend of the post-reset snapshot
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        check("rst2_overrun", overrun, 0);
        step();
        rx0 = rx_count; d0 = done_count;
        for (int n = 0; n < 3; n++) push_pkt(12'h000, 12'h000, 12'h000, 12'h000);
        continuous = 1'b1;
        wait_rx_to(rx0 + 2 * NB + 4, 1200, "cont_reach_byte4");
        enable = 1'b0;
        wait_done_to(d0 + 3, 400, "cont_done");
        p0 = pulses;
        repeat (60) step();
        check("cont_stop", pulses - p0, 0);
        check("cont_bytes", rx_count - rx0, 3 * NB);
        check("cont_queue", exp_q.size(), 0);
        continuous = 1'b0;
        enable = 1'b1;

        // Reset in the middle of the payload
        push_pkt(12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F);
        do_update(12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F);
        wait_rx_to(rx_count + SB + 5, 400, "mid_reach");
        rst_n = 1'b0;
        step();
        check("mid_rst_start", tx_start, 0);
        check("mid_rst_data", tx_data, 8'h00);
        check("mid_rst_active", active, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overrun", overrun, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        p0 = pulses;
        repeat (40) step();
        check("mid_no_pulse", pulses - p0, 0);
        d0 = done_count;
        push_pkt(12'h777, 12'h888, 12'h999, 12'hFFF);
        do_update(12'h777, 12'h888, 12'h999, 12'hFFF);
        wait_done_to(d0 + 1, 400, "mid_after_done");
        check("mid_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
